tlc_phase_scheduler: RTL and testbench
======================================

TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 Parameters SHALL be, as name, default (clock cycles), meaning:
 - HWY_MIN, 2000000000, minimum highway green.
 - FARM_MIN, 300000000, minimum farm green.
 - FARM_MAX, 1500000000, maximum farm green.
 - YEL, 300000000, yellow time.
 - ALLRED, 100000000, all-red clearance.
 - WALK, 1000000000, pedestrian walk time.
 - Every parameter SHALL be >=1 and <2^31; FARM_MIN <= FARM_MAX.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
 - Clk, input, 1, sole clock, rising edge.
 - Rst, input, 1, asynchronous active-high reset.
 - farmSensor, input, 1, level-sensitive car-present request, synchronous to Clk.
 - pedButton, input, 1, pedestrian request, synchronous to Clk, any pulse width.
 - highwaySignal, output, 2, highway lamp.
 - farmSignal, output, 2, farm lamp.
 - walkSignal, output, 1, walk lamp.
 - state, output, 3, current state code (debug).
 - RstCount, output, 1, high in any cycle where the next edge clears the timer (debug).
REQ-003 Lamp encoding SHALL be RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 SHALL never be driven.

Function
REQ-004 States and codes SHALL be HWY_G=0, HWY_Y=1, AR_A=2, FARM_G=3, FARM_Y=4, WALK=5, AR_B=6; code 7 SHALL go to HWY_G on the next edge.
REQ-005 Outputs SHALL be a function of the state register only:
 - highwaySignal is GREEN in HWY_G, YELLOW in HWY_Y, RED otherwise.
 - farmSignal is GREEN in FARM_G, YELLOW in FARM_Y, RED otherwise.
 - walkSignal=1 only in WALK.
REQ-006 A 31-bit timer Count SHALL clear to 0 on every state transition and otherwise increment, saturating at 2^31-1 (no wrap).
REQ-007 A state with fixed time T (HWY_Y/FARM_Y=YEL, AR_A/AR_B=ALLRED, WALK=WALK) SHALL last exactly T cycles, i.e. exit on the edge where Count==T-1.
REQ-008 HWY_G SHALL go to HWY_Y when Count>=HWY_MIN-1 and (farmSensor or pedPending) are both true; otherwise it remains, indefinitely.
REQ-009 AR_A exit SHALL go to:
 - FARM_G if only farmSensor is set.
 - WALK if only pedPending is set.
 - Whichever of FARM_G/WALK was not lastServed if both are set.
 - HWY_G if neither is set.
REQ-010 FARM_G SHALL go to FARM_Y when Count==FARM_MAX-1, or when Count>=FARM_MIN-1 and farmSensor==0.
REQ-011 Sequencing SHALL be FARM_Y->AR_B, WALK->AR_B, AR_B->HWY_G.
REQ-012 pedPending SHALL set on any cycle with pedButton=1 while not in WALK, and clear on the edge entering WALK; clear wins over set on that edge; pedButton in WALK is ignored.
REQ-013 lastServed SHALL update to FARM or WALK on the edge entering FARM_G or WALK respectively.
REQ-014 RstCount SHALL equal 1 exactly when a transition is taken at the next edge.

Reset
REQ-015 Rst=1 SHALL immediately, without a clock, force:
 - state=HWY_G, Count=0, pedPending=0, lastServed=WALK.
 - Outputs highwaySignal=GREEN, farmSignal=RED, walkSignal=0.
REQ-016 Reset asserted in any state SHALL abort the sequence with no yellow or all-red phase; operation resumes from HWY_G on the first edge after release.

Verification (HWY_MIN=4, FARM_MIN=3, FARM_MAX=6, YEL=2, ALLRED=1, WALK=5)
REQ-017 Reset release, no requests, 100 cycles -> state=0 throughout, highwaySignal=2'b10, farmSignal=2'b00, Count saturation not reached and no wrap.
REQ-018 farmSensor held 1 from reset release -> HWY_G 4, HWY_Y 2, AR_A 1, FARM_G 6, FARM_Y 2, AR_B 1 cycles, then HWY_G; RstCount pulses once per transition.
REQ-019 farmSensor dropped in the 1st FARM_G cycle -> FARM_G lasts exactly 3 cycles.
REQ-020 farmSensor=1 and a 1-cycle pedButton pulse before AR_A exit -> FARM_G served first, then HWY_G; WALK follows the next highway cycle with walkSignal=1 for 5 cycles and both lamps RED.
REQ-021 pedButton pulses during WALK -> no second WALK; pedButton on the WALK-entry edge -> pedPending=0 afterward.
REQ-022 Rst pulsed mid-FARM_G -> same-cycle state=0, highwaySignal=2'b10, farmSignal=2'b00, pedPending=0.

Source files
------------

// File: rtl/tlc_phase_scheduler.sv
// rtl/tlc_phase_scheduler.sv - highway/farm traffic light phase scheduler with pedestrian walk phase
// Timers count cycles spent in the current state; each phase exits on its last cycle.
module tlc_phase_scheduler #(
  parameter int HWY_MIN  = 2000000000,
  parameter int FARM_MIN = 300000000,
  parameter int FARM_MAX = 1500000000,
  parameter int YEL      = 300000000,
  parameter int ALLRED   = 100000000,
  parameter int WALK     = 1000000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       farmSensor,
  input  logic       pedButton,
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic       walkSignal,
  output logic [2:0] state,
  output logic       RstCount
);

  typedef enum logic [2:0] {
    S_HWY_G  = 3'd0,
    S_HWY_Y  = 3'd1,
    S_AR_A   = 3'd2,
    S_FARM_G = 3'd3,
    S_FARM_Y = 3'd4,
    S_WALK   = 3'd5,
    S_AR_B   = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  localparam logic [30:0] HWY_LIM   = 31'(HWY_MIN - 1);
  localparam logic [30:0] FMIN_LIM  = 31'(FARM_MIN - 1);
  localparam logic [30:0] FMAX_LIM  = 31'(FARM_MAX - 1);
  localparam logic [30:0] YEL_LIM   = 31'(YEL - 1);
  localparam logic [30:0] AR_LIM    = 31'(ALLRED - 1);
  localparam logic [30:0] WALK_LIM  = 31'(WALK - 1);
  localparam logic [30:0] COUNT_SAT = '1;

  state_t      state_q, state_d;
  logic [30:0] count_q, count_d;
  logic        ped_pending_q, ped_pending_d;
  logic        last_walk_q, last_walk_d;
  logic        enter_walk;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_HWY_G;
      count_q       <= '0;
      ped_pending_q <= 1'b0;
      last_walk_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ped_pending_q <= ped_pending_d;
      last_walk_q   <= last_walk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HWY_G:  if (count_q >= HWY_LIM && (farmSensor || ped_pending_q)) state_d = S_HWY_Y;
      S_HWY_Y:  if (count_q == YEL_LIM) state_d = S_AR_A;
      S_AR_A: begin
        // With both requests waiting, alternate away from whichever was served last.
        if (count_q == AR_LIM) begin
          if (farmSensor && ped_pending_q) state_d = last_walk_q ? S_FARM_G : S_WALK;
          else if (farmSensor)             state_d = S_FARM_G;
          else if (ped_pending_q)          state_d = S_WALK;
          else                             state_d = S_HWY_G;
        end
      end
      S_FARM_G: if (count_q == FMAX_LIM || (count_q >= FMIN_LIM && !farmSensor)) state_d = S_FARM_Y;
      S_FARM_Y: if (count_q == YEL_LIM) state_d = S_AR_B;
      S_WALK:   if (count_q == WALK_LIM) state_d = S_AR_B;
      S_AR_B:   if (count_q == AR_LIM) state_d = S_HWY_G;
      default:  state_d = S_HWY_G;
    endcase

    RstCount = (state_d != state_q);
    count_d  = RstCount ? '0 : ((count_q == COUNT_SAT) ? count_q : count_q + 31'd1);

    enter_walk    = (state_d == S_WALK) && (state_q != S_WALK);
    ped_pending_d = enter_walk ? 1'b0 : (ped_pending_q || (pedButton && state_q != S_WALK));

    last_walk_d = last_walk_q;
    if (enter_walk) last_walk_d = 1'b1;
    else if (state_d == S_FARM_G && state_q != S_FARM_G) last_walk_d = 1'b0;
  end

  always_comb begin
    highwaySignal = LAMP_RED;
    farmSignal    = LAMP_RED;
    walkSignal    = 1'b0;
    case (state_q)
      S_HWY_G:  highwaySignal = LAMP_GREEN;
      S_HWY_Y:  highwaySignal = LAMP_YELLOW;
      S_FARM_G: farmSignal    = LAMP_GREEN;
      S_FARM_Y: farmSignal    = LAMP_YELLOW;
      S_WALK:   walkSignal    = 1'b1;
      default:  ;
    endcase
    state = state_q;
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb/tb_tlc_phase_scheduler.sv - phase-duration model bench for tlc_phase_scheduler
// Scripted scenarios pin exact phase lengths, then randomized traffic runs against the model.
module tb_tlc_phase_scheduler;
  localparam int HWY_MIN = 4, FARM_MIN = 3, FARM_MAX = 6, YEL = 2, ALLRED = 1, WALK = 5;

  logic       Clk = 1'b0;
  logic       Rst, farmSensor, pedButton;
  logic [1:0] highwaySignal, farmSignal;
  logic       walkSignal, RstCount;
  logic [2:0] state;

  always #5 Clk = ~Clk;

  tlc_phase_scheduler #(
    .HWY_MIN(HWY_MIN), .FARM_MIN(FARM_MIN), .FARM_MAX(FARM_MAX),
    .YEL(YEL), .ALLRED(ALLRED), .WALK(WALK)
  ) dut (
    .Clk(Clk), .Rst(Rst), .farmSensor(farmSensor), .pedButton(pedButton),
    .highwaySignal(highwaySignal), .farmSignal(farmSignal), .walkSignal(walkSignal),
    .state(state), .RstCount(RstCount)
  );

  int checks = 0, errors = 0;
  // Model: phase number, cycles already spent in it, pending walk request, who was served last.
  int m_phase, m_t;
  bit m_ped, m_last_walk;
  // Observed DUT phase runs, plus counters used by the scripted pins.
  int runs_state[$], runs_len[$];
  int obs_prev, obs_len, rc_cnt, walk_red_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_next(input bit farm);
    int el = m_t + 1;
    case (m_phase)
      0: return (el >= HWY_MIN && (farm || m_ped)) ? 1 : 0;
      1: return (el == YEL) ? 2 : 1;
      2: begin
        if (el != ALLRED) return 2;
        if (farm && m_ped) return m_last_walk ? 3 : 5;
        if (farm) return 3;
        if (m_ped) return 5;
        return 0;
      end
      3: return (el == FARM_MAX || (el >= FARM_MIN && !farm)) ? 4 : 3;
      4: return (el == YEL) ? 6 : 4;
      5: return (el == WALK) ? 6 : 5;
      default: return (el == ALLRED) ? 0 : 6;
    endcase
  endfunction

  task automatic cycle();
    int nxt;
    @(negedge Clk);
    nxt = model_next(farmSensor);
    chk("state", {29'd0, state}, m_phase);
    chk("highway_lamp", {30'd0, highwaySignal}, (m_phase == 0) ? 2 : (m_phase == 1) ? 1 : 0);
    chk("farm_lamp", {30'd0, farmSignal}, (m_phase == 3) ? 2 : (m_phase == 4) ? 1 : 0);
    chk("walk_lamp", {31'd0, walkSignal}, (m_phase == 5) ? 1 : 0);
    chk("rst_count", {31'd0, RstCount}, (nxt != m_phase) ? 1 : 0);
    if (RstCount === 1'b1) rc_cnt++;
    if (walkSignal === 1'b1 && highwaySignal === 2'b00 && farmSignal === 2'b00) walk_red_cycles++;
    if (int'(state) == obs_prev) obs_len++;
    else begin
      runs_state.push_back(obs_prev);
      runs_len.push_back(obs_len);
      obs_prev = int'(state);
      obs_len  = 1;
    end
    @(posedge Clk);
    if (pedButton && m_phase != 5) m_ped = 1'b1;
    if (nxt == 5 && m_phase != 5) begin m_ped = 1'b0; m_last_walk = 1'b1; end
    if (nxt == 3 && m_phase != 3) m_last_walk = 1'b0;
    m_t     = (nxt == m_phase) ? m_t + 1 : 0;
    m_phase = nxt;
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #2;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_highway", {30'd0, highwaySignal}, 2);
    chk("rst_farm", {30'd0, farmSignal}, 0);
    chk("rst_walk", {31'd0, walkSignal}, 0);
    chk("rst_ped_pending", {31'd0, dut.ped_pending_q}, 0);
    m_phase = 0; m_t = 0; m_ped = 1'b0; m_last_walk = 1'b1;
    runs_state.delete(); runs_len.delete();
    obs_prev = 0; obs_len = 0; rc_cnt = 0; walk_red_cycles = 0;
    @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  int exp_st[6] = '{0, 1, 2, 3, 4, 6};
  int exp_ln[6] = '{4, 2, 1, 6, 2, 1};

  initial begin
    Rst = 1'b1; farmSensor = 1'b0; pedButton = 1'b0;

    do_reset();
    for (int i = 0; i < 100; i++) cycle();
    chk("idle_no_transition", runs_state.size(), 0);
    chk("idle_len", obs_len, 100);

    do_reset();
    farmSensor = 1'b1;
    for (int i = 0; i < 19; i++) cycle();
    chk("farm_run_count", runs_state.size(), 6);
    for (int i = 0; i < 6 && i < runs_state.size(); i++) begin
      chk($sformatf("farm_run%0d_state", i), runs_state[i], exp_st[i]);
      chk($sformatf("farm_run%0d_len", i), runs_len[i], exp_ln[i]);
    end
    chk("farm_rstcount_pulses", rc_cnt, 6);

    do_reset();
    farmSensor = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    farmSensor = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("farm_min_runs", runs_state.size() > 3, 1);
    if (runs_state.size() > 3) begin
      chk("farm_min_state", runs_state[3], 3);
      chk("farm_min_len", runs_len[3], 3);
    end

    do_reset();
    farmSensor = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pedButton = (i == 0);
      cycle();
    end
    pedButton = 1'b0;
    chk("both_runs", runs_state.size() > 10, 1);
    if (runs_state.size() > 10) begin
      chk("both_first_farm", runs_state[3], 3);
      chk("both_back_hwy", runs_state[6], 0);
      chk("both_walk_state", runs_state[9], 5);
      chk("both_walk_len", runs_len[9], 5);
    end
    chk("walk_all_red_cycles", walk_red_cycles, 5);

    do_reset();
    farmSensor = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pedButton = (i == 0 || i == 6 || i == 8 || i == 10);
      cycle();
      if (i == 7) chk("ped_cleared_on_walk_entry", {31'd0, dut.ped_pending_q}, 0);
    end
    pedButton = 1'b0;
    chk("single_walk_runs", runs_state.size(), 5);
    chk("single_walk_idle", obs_prev, 0);
    chk("single_walk_ped_after", {31'd0, dut.ped_pending_q}, 0);

    do_reset();
    farmSensor = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pedButton = (i == 0);
      cycle();
    end
    pedButton = 1'b0;
    chk("mid_farm_state", {29'd0, state}, 3);
    do_reset();
    farmSensor = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) farmSensor = ~farmSensor;
      pedButton = ($urandom_range(19) == 0);
      if ($urandom_range(499) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
